// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-requester round-robin arbiter/sequencer for data_memory (optional DMEM_ARB_RANGE_CHECK_EN)
module data_mem_arbiter #(
    parameter int N = 32,
    parameter int M = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic         ack0,
    output logic         ack1,
    output logic [N-1:0] rdata0,
    output logic [N-1:0] rdata1,
    output logic         err0,
    output logic         err1,
    output logic         busy,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_data_input,
    output logic         mem_memread,
    output logic         mem_memwrite,
    input  logic [N-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;

    // Transaction latched at grant; mem_address/mem_data_input hold addr/wdata
    logic         last_grant;
    logic         cur_id;
    logic         cur_we;
    logic         cur_err;

    // Winner of the current arbitration and its request fields
    logic         gnt_id;
    logic         sel_we;
    logic [N-1:0] sel_addr;
    logic [N-1:0] sel_wdata;
    logic         sel_in_range;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic [N:0] ADDR_LIMIT = (N+1)'(M);
    assign sel_in_range = ({1'b0, sel_addr} < ADDR_LIMIT);
`else
    assign sel_in_range = 1'b1;
`endif

    // Round-robin winner selection and next-state decode
    always_comb begin
        next_state = state;
        gnt_id     = 1'b0;
        if (req0 && req1) begin
            gnt_id = ~last_grant;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
        sel_we    = gnt_id ? we1    : we0;
        sel_addr  = gnt_id ? addr1  : addr0;
        sel_wdata = gnt_id ? wdata1 : wdata0;
        case (state)
            IDLE:    if (req0 || req1) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered datapath: latch on grant, drive strobes for one cycle, ack afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant     <= 1'b1;
            cur_id         <= 1'b0;
            cur_we         <= 1'b0;
            cur_err        <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            err0           <= 1'b0;
            err1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            busy           <= 1'b0;
            mem_address    <= '0;
            mem_data_input <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        last_grant     <= gnt_id;
                        cur_id         <= gnt_id;
                        cur_we         <= sel_we;
                        cur_err        <= ~sel_in_range;
                        mem_address    <= sel_addr;
                        mem_data_input <= sel_wdata;
                        mem_memread    <= ~sel_we & sel_in_range;
                        mem_memwrite   <= sel_we & sel_in_range;
                        busy           <= 1'b1;
                    end
                end
                ACCESS: begin
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    if (cur_id) begin
                        ack1 <= 1'b1;
                        err1 <= cur_err;
                        if (!cur_we && !cur_err) rdata1 <= mem_data;
                    end else begin
                        ack0 <= 1'b1;
                        err0 <= cur_err;
                        if (!cur_we && !cur_err) rdata0 <= mem_data;
                    end
                end
                RESP: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
